// File: rtl/fb_pkg.sv
// Shared frame-buffer types and widths, common to the renderer and the read server.
package fb_pkg;
    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_PUSH = 2'd2,
        WR      = 2'd3
    } fb_state_t;
endpackage

// File: rtl/fb_rw_arbiter.sv
// Round-robin grant between display reads and drawing-side writes.
// Keeps one bit of history: which kind was granted last.
module fb_rw_arbiter
    import fb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic rd_elig,
    input  logic wr_elig,
    output logic grant_rd,
    output logic grant_wr
);
    logic favour_wr;

    always_comb begin
        grant_rd = arb_en && rd_elig && (!wr_elig || !favour_wr);
        grant_wr = arb_en && wr_elig && (!rd_elig || favour_wr);
    end

    // After reset reads win a tie; afterwards a tie goes to whichever kind lost last time.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour_wr <= 1'b0;
        end else if (grant_rd) begin
            favour_wr <= 1'b1;
        end else if (grant_wr) begin
            favour_wr <= 1'b0;
        end
    end
endmodule

// File: rtl/fb_read_server.sv
// Frame-buffer responder: address FIFO -> memory read -> data FIFO, plus arbitrated writes.
// FB_TEST_PATTERN_EN: reads skip memory and push the request address back as data.
//
// state   | meaning
// IDLE    | arbitrate between a pending read and a pending write
// RD_WAIT | read issued, counting down memory latency
// RD_PUSH | read word on fb_data_out_wd with wen high
// WR      | write strobe and ack high for one cycle
module fb_read_server
    import fb_pkg::*;
#(
    parameter int RD_LATENCY = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FB_ADDR_W-1:0] fb_addr_in_rd,
    input  logic                 fb_addr_in_empty,
    output logic                 fb_addr_in_ren,
    output logic [FB_DATA_W-1:0] fb_data_out_wd,
    output logic                 fb_data_out_wen,
    input  logic                 fb_data_out_full,
    input  logic                 wr_req,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [FB_DATA_W-1:0] wr_data,
    output logic                 wr_ack,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [FB_DATA_W-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [FB_DATA_W-1:0] mem_rdata
);
`ifdef FB_TEST_PATTERN_EN
    localparam bit TEST_PATTERN = 1'b1;
`else
    localparam bit TEST_PATTERN = 1'b0;
`endif

    fb_state_t  state;
    logic [2:0] lat_cnt;
    logic       grant_rd;
    logic       grant_wr;

    fb_rw_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state == IDLE),
        .rd_elig  (!fb_addr_in_empty && !fb_data_out_full),
        .wr_elig  (wr_req),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            lat_cnt         <= 3'd0;
            fb_addr_in_ren  <= 1'b0;
            fb_data_out_wd  <= '0;
            fb_data_out_wen <= 1'b0;
            wr_ack          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
        end else begin
            fb_addr_in_ren  <= 1'b0;
            fb_data_out_wen <= 1'b0;
            wr_ack          <= 1'b0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        fb_addr_in_ren <= 1'b1;
                        mem_re         <= ~TEST_PATTERN;
                        mem_addr       <= fb_addr_in_rd;
                        lat_cnt        <= 3'(RD_LATENCY);
                        state          <= RD_WAIT;
                    end else if (grant_wr) begin
                        mem_we    <= 1'b1;
                        wr_ack    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                        state     <= WR;
                    end
                end
                RD_WAIT: begin
                    // Count starts at the edge the memory sees the strobe, i.e. after the issue cycle.
                    if (!fb_addr_in_ren) begin
                        if (lat_cnt == 3'd1) begin
                            fb_data_out_wd  <= TEST_PATTERN ? mem_addr : mem_rdata;
                            fb_data_out_wen <= 1'b1;
                            state           <= RD_PUSH;
                        end
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RD_PUSH: state <= IDLE;
                WR:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_read_server.sv
// Directed bench for fb_read_server with FIFO/memory models and an in-order read scoreboard.
module tb_fb_read_server;
    localparam int LAT = 2;
`ifdef FB_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fb_addr_in_rd;
    logic        fb_addr_in_empty;
    logic        fb_addr_in_ren;
    logic [15:0] fb_data_out_wd;
    logic        fb_data_out_wen;
    logic        fb_data_out_full;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    fb_read_server #(.RD_LATENCY(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .fb_addr_in_rd    (fb_addr_in_rd),
        .fb_addr_in_empty (fb_addr_in_empty),
        .fb_addr_in_ren   (fb_addr_in_ren),
        .fb_data_out_wd   (fb_data_out_wd),
        .fb_data_out_wen  (fb_data_out_wen),
        .fb_data_out_full (fb_data_out_full),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ren_count = 0;
    int          wen_count = 0;
    int          re_count = 0;
    int          outstanding = 0;
    int          last_ren_cyc = 0;
    logic [15:0] addr_q[$];
    logic [15:0] sb[$];
    int          wen_cyc[$];
    logic [15:0] mem_model[bit [15:0]];
    logic [15:0] pipe[LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_word(a);
    endfunction

    task automatic refresh_fifo();
        fb_addr_in_empty = (addr_q.size() == 0);
        fb_addr_in_rd    = fb_addr_in_empty ? 16'h0000 : addr_q[0];
    endtask

    task automatic push_rd(input logic [15:0] a, input logic [15:0] exp_mem);
        addr_q.push_back(a);
        sb.push_back(TP ? a : exp_mem);
        refresh_fifo();
    endtask

    // One cycle: advance to the falling edge, run the memory/FIFO models, check pushes.
    task automatic tick();
        logic [15:0] dummy;
        @(negedge clk);
        cyc++;
        mem_rdata = pipe[LAT-1];
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = mem_re ? model_read(mem_addr) : 16'hDEAD;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        if (mem_re) re_count++;
        if (mem_re || mem_we) chk("re_we_exclusive", 32'(mem_re && mem_we), 32'd0);
        if (fb_addr_in_ren) begin
            chk("single_in_flight", 32'(outstanding), 32'd0);
            outstanding  = 1;
            ren_count++;
            last_ren_cyc = cyc;
            if (addr_q.size() > 0) dummy = addr_q.pop_front();
            refresh_fifo();
        end
        if (fb_data_out_wen) begin
            chk("push_has_read", 32'(outstanding), 32'd1);
            outstanding = 0;
            wen_count++;
            wen_cyc.push_back(cyc);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("push_data", 32'(fb_data_out_wd), 32'(sb.pop_front()));
        end
    endtask

    function automatic bit sel(input int which);
        case (which)
            0:       return fb_addr_in_ren;
            1:       return fb_data_out_wen;
            default: return wr_ack;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = sel(which);
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((addr_q.size() > 0 || outstanding != 0) && guard < 200) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk(tag, 32'(addr_q.size() + outstanding), 32'd0);
    endtask

    initial begin
        int          c0;
        int          r0;
        int          w0;
        logic [15:0] dummy;
        rst = 1'b1;
        fb_data_out_full = 1'b0;
        wr_req = 1'b0;
        wr_addr = 16'h0000;
        wr_data = 16'h0000;
        mem_rdata = 16'h0000;
        for (int i = 0; i < LAT; i++) pipe[i] = 16'hDEAD;
        refresh_fifo();

        repeat (3) tick();
        chk("rst_strobes", 32'({fb_addr_in_ren, fb_data_out_wen, wr_ack, mem_we, mem_re}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wd", 32'(fb_data_out_wd), 32'd0);
        rst = 1'b0;
        tick();

        // Single read: 0x0123 returns 0xBEEF
        push_rd(16'h0123, 16'hBEEF);
        c0 = cyc;
        r0 = ren_count;
        wait_for(0, 5, "single_ren_timeout");
        chk("single_issue_latency", 32'(last_ren_cyc - c0), 32'd1);
        chk("single_mem_re", 32'(mem_re), TP ? 32'd0 : 32'd1);
        chk("single_mem_addr", 32'(mem_addr), 32'h0123);
        wait_for(1, 10, "single_wen_timeout");
        chk("single_push_latency", 32'(wen_cyc[$] - last_ren_cyc), 32'(LAT + 1));
        repeat (4) tick();
        chk("single_ren_pulses", 32'(ren_count - r0), 32'd1);

        // Back-to-back reads, order and spacing
        w0 = wen_cyc.size();
        for (int a = 1; a <= 4; a++) push_rd(16'(a), init_word(16'(a)));
        for (int i = 0; i < 60 && wen_cyc.size() < w0 + 4; i++) tick();
        chk("b2b_push_count", 32'(wen_cyc.size() - w0), 32'd4);
        for (int i = 1; i < 4; i++)
            if (wen_cyc.size() >= w0 + 4)
                chk("b2b_spacing", 32'(wen_cyc[w0+i] - wen_cyc[w0+i-1]), 32'(LAT + 3));
        drain("b2b_drain");

        // Data FIFO full blocks reads
        fb_data_out_full = 1'b1;
        push_rd(16'h0100, init_word(16'h0100));
        push_rd(16'h0101, init_word(16'h0101));
        r0 = ren_count;
        repeat (8) tick();
        chk("full_no_ren", 32'(ren_count - r0), 32'd0);
        chk("full_fifo_kept", 32'(addr_q.size()), 32'd2);
        fb_data_out_full = 1'b0;
        tick();
        chk("full_release_ren", 32'(fb_addr_in_ren), 32'd1);
        drain("full_drain");

        // Write among continuous reads
        for (int a = 0; a < 6; a++) push_rd(16'h0200 + 16'(a), init_word(16'h0200 + 16'(a)));
        wait_for(0, 5, "wr_mix_ren_timeout");
        wr_req = 1'b1;
        wr_addr = 16'h0040;
        wr_data = 16'h5555;
        r0 = ren_count;
        wait_for(2, 30, "wr_mix_ack_timeout");
        chk("wr_mix_wait_le1", 32'((ren_count - r0) <= 1), 32'd1);
        chk("wr_mix_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mix_mem_addr", 32'(mem_addr), 32'h0040);
        chk("wr_mix_mem_wdata", 32'(mem_wdata), 32'h5555);
        chk("wr_mix_no_re", 32'(mem_re), 32'd0);
        wr_req = 1'b0;
        tick();
        chk("wr_mix_ack_pulse", 32'({wr_ack, mem_we}), 32'd0);
        drain("wr_mix_drain");

        // Read-after-write and an isolated write
        push_rd(16'h0040, 16'h5555);
        drain("raw_drain");
        wr_req = 1'b1;
        wr_addr = 16'hFFFF;
        wr_data = 16'hA00A;
        tick();
        chk("wr_solo_ack", 32'({wr_ack, mem_we}), 32'd3);
        chk("wr_solo_addr", 32'(mem_addr), 32'hFFFF);
        wr_req = 1'b0;
        tick();
        chk("wr_solo_ack_pulse", 32'(wr_ack), 32'd0);
        push_rd(16'hFFFF, 16'hA00A);
        drain("wr_solo_drain");

        // Reset during RD_WAIT drops the read
        push_rd(16'h0300, init_word(16'h0300));
        wait_for(0, 5, "rst_mid_ren_timeout");
        tick();
        w0 = wen_count;
        rst = 1'b1;
        tick();
        chk("rst_mid_strobes", 32'({fb_addr_in_ren, fb_data_out_wen, wr_ack, mem_we, mem_re}), 32'd0);
        chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        outstanding = 0;
        dummy = sb.pop_back();
        repeat (10) tick();
        chk("rst_mid_no_push", 32'(wen_count - w0), 32'd0);

        // After reset a read wins a tie, then the write goes next
        push_rd(16'h0400, init_word(16'h0400));
        wr_req = 1'b1;
        wr_addr = 16'h0041;
        wr_data = 16'h1234;
        tick();
        chk("tie_read_first", 32'({fb_addr_in_ren, wr_ack}), 32'd2);
        wait_for(2, 15, "tie_ack_timeout");
        chk("tie_wr_addr", 32'(mem_addr), 32'h0041);
        wr_req = 1'b0;
        drain("tie_drain");

        chk("mem_re_vs_reads", 32'(re_count), TP ? 32'd0 : 32'(ren_count));
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
